// File: rtl/scope_pkg.sv
// Shared constants and capture-state encoding for the scope acquisition path.
package scope_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_DEPTH_LOG2 = 10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_DONE    = 3'd4
  } state_t;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port (EBR-friendly, no reset).
module capture_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// Circular-buffer ADC capture with pre-trigger fill, level-crossing trigger and oldest-first readout.
module adc_trigger_capture
  import scope_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int PRE_TRIG   = 256
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SAMPLE_STB,
  input  logic [DATA_W-1:0]     ADC_DATA,
  input  logic                  ARM,
  input  logic [DATA_W-1:0]     TRIG_LEVEL,
  input  logic                  TRIG_RISING,
  input  logic                  FORCE_TRIG,
  input  logic                  RD_EN,
  output logic [DATA_W-1:0]     RD_DATA,
  output logic                  RD_VALID,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [DEPTH_LOG2-1:0] TRIG_POS
);

  localparam int DEPTH    = 2**DEPTH_LOG2;
  localparam int POST_LEN = DEPTH - PRE_TRIG - 1;
  localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE_TRIG - 1);
  localparam logic [DEPTH_LOG2-1:0] POST_LOAD = DEPTH_LOG2'(POST_LEN);
  localparam logic [DEPTH_LOG2-1:0] ONE       = DEPTH_LOG2'(1);

  state_t state, state_nxt;

  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, pre_cnt, post_cnt, trig_pos;
  logic [DATA_W-1:0]     prev;
  logic                  force_q;
  logic                  wr_en, rd_en_p0, trig_hit;
  logic                  rd_vld_p1;
  logic [DATA_W-1:0]     ram_q_p1;

  function automatic logic crossed(input logic [DATA_W-1:0] p, input logic [DATA_W-1:0] c,
                                   input logic [DATA_W-1:0] lvl, input logic rising);
    if (rising) return (p < lvl) && (c >= lvl);
    else        return (p > lvl) && (c <= lvl);
  endfunction

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    wr_en     = 1'b0;
    rd_en_p0  = 1'b0;
    trig_hit  = 1'b0;
    case (state)
      S_IDLE: ;
      S_PREFILL: begin
        BUSY  = 1'b1;
        wr_en = SAMPLE_STB;
        if (SAMPLE_STB && pre_cnt == PRE_LAST) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        BUSY     = 1'b1;
        wr_en    = SAMPLE_STB;
        trig_hit = SAMPLE_STB && (force_q || crossed(prev, ADC_DATA, TRIG_LEVEL, TRIG_RISING));
        if (trig_hit) state_nxt = (POST_LEN == 0) ? S_DONE : S_POST;
      end
      S_POST: begin
        BUSY  = 1'b1;
        wr_en = SAMPLE_STB;
        if (SAMPLE_STB && post_cnt == ONE) state_nxt = S_DONE;
      end
      S_DONE: begin
        DONE     = 1'b1;
        rd_en_p0 = RD_EN;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A new arm wins over everything else in the same cycle, including its own strobe.
    if (ARM) begin
      state_nxt = S_PREFILL;
      wr_en     = 1'b0;
      rd_en_p0  = 1'b0;
      trig_hit  = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pre_cnt   <= '0;
      post_cnt  <= '0;
      trig_pos  <= '0;
      prev      <= '0;
      force_q   <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else if (ARM) begin
      wr_ptr    <= '0;
      pre_cnt   <= '0;
      force_q   <= 1'b0;
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= rd_en_p0;
      if (wr_en) begin
        wr_ptr <= wr_ptr + ONE;
        prev   <= ADC_DATA;
      end
      if (wr_en && state == S_PREFILL) pre_cnt <= pre_cnt + ONE;
      if (state == S_ARMED) begin
        if (trig_hit)        force_q <= 1'b0;
        else if (FORCE_TRIG) force_q <= 1'b1;
      end else begin
        force_q <= 1'b0;
      end
      if (trig_hit) begin
        trig_pos <= wr_ptr;
        post_cnt <= POST_LOAD;
      end
      if (wr_en && state == S_POST) post_cnt <= post_cnt - ONE;
      // The slot after the final write is the oldest sample of the frozen record.
      if (state_nxt == S_DONE && state != S_DONE) rd_ptr <= wr_ptr + ONE;
      if (rd_en_p0) rd_ptr <= rd_ptr + ONE;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_ram (
    .CLK     (CLK),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr),
    .wr_data (ADC_DATA),
    .rd_en   (rd_en_p0),
    .rd_addr (rd_ptr),
    .rd_data (ram_q_p1)
  );

  // ---- read stage p1: RAM output qualified by the resettable valid ----
  assign RD_VALID = rd_vld_p1;
  assign RD_DATA  = rd_vld_p1 ? ram_q_p1 : '0;
  assign TRIG_POS = trig_pos;

endmodule

// File: tb/tb_adc_trigger_capture.sv
// Randomized and directed bench for adc_trigger_capture against a stream-level reference model.
module tb_adc_trigger_capture;

  localparam int PRE   = 4;
  localparam int DEPTH = 16;
  localparam int POST  = DEPTH - PRE - 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       SAMPLE_STB = 1'b0;
  logic [7:0] ADC_DATA = 8'h00;
  logic       ARM = 1'b0;
  logic [7:0] TRIG_LEVEL = 8'h80;
  logic       TRIG_RISING = 1'b1;
  logic       FORCE_TRIG = 1'b0;
  logic       RD_EN = 1'b0;
  logic [7:0] RD_DATA;
  logic       RD_VALID;
  logic       BUSY;
  logic       DONE;
  logic [3:0] TRIG_POS;

  int n_chk  = 0;
  int n_pass = 0;
  logic [7:0] stim[$];

  adc_trigger_capture #(.DATA_W(8), .DEPTH_LOG2(4), .PRE_TRIG(PRE)) dut (
    .CLK(CLK), .RST(RST), .SAMPLE_STB(SAMPLE_STB), .ADC_DATA(ADC_DATA), .ARM(ARM),
    .TRIG_LEVEL(TRIG_LEVEL), .TRIG_RISING(TRIG_RISING), .FORCE_TRIG(FORCE_TRIG),
    .RD_EN(RD_EN), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID), .BUSY(BUSY), .DONE(DONE),
    .TRIG_POS(TRIG_POS)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Reference: the record is the contiguous stretch of the stream around the first trigger.
  function automatic int model_trig(input int force_idx);
    for (int i = PRE; i < stim.size(); i++) begin
      if (i == force_idx) return i;
      if (TRIG_RISING ? (stim[i-1] < TRIG_LEVEL && stim[i] >= TRIG_LEVEL)
                      : (stim[i-1] > TRIG_LEVEL && stim[i] <= TRIG_LEVEL)) return i;
    end
    return -1;
  endfunction

  task automatic arm;
    ARM = 1'b1;
    tick();
    ARM = 1'b0;
    stim.delete();
  endtask

  task automatic do_capture(input string name, input int force_idx, output int t);
    bit done_exp;
    t = model_trig(force_idx);
    for (int j = 0; j < stim.size(); j++) begin
      for (int g = 0; g < 4; g++) begin
        FORCE_TRIG = (j == force_idx && g == 2);
        tick();
      end
      FORCE_TRIG = 1'b0;
      SAMPLE_STB = 1'b1;
      ADC_DATA   = stim[j];
      tick();
      SAMPLE_STB = 1'b0;
      done_exp = (t >= 0) && (j >= t + POST);
      n_chk++;
      if (DONE !== done_exp || BUSY !== !done_exp)
        $display("FAIL %s done/busy after sample %0d: DONE=%b BUSY=%b, required DONE=%b BUSY=%b",
                 name, j, DONE, BUSY, done_exp, !done_exp);
      else n_pass++;
    end
    if (t >= 0 && t + POST < stim.size()) begin
      n_chk++;
      if (TRIG_POS !== 4'(t))
        $display("FAIL %s trig_pos: got %0d, required %0d", name, TRIG_POS, t % DEPTH);
      else n_pass++;
    end
  endtask

  task automatic do_read(input string name, input int t, input int n, input bit burst);
    logic [7:0] exp;
    if (burst) RD_EN = 1'b1;
    for (int k = 0; k < n; k++) begin
      exp = stim[t - PRE + (k % DEPTH)];
      if (!burst) RD_EN = 1'b1;
      tick();
      if (!burst) RD_EN = 1'b0;
      n_chk++;
      if (RD_VALID !== 1'b1 || RD_DATA !== exp)
        $display("FAIL %s read %0d: valid=%b data=%h, required valid=1 data=%h",
                 name, k, RD_VALID, RD_DATA, exp);
      else n_pass++;
      if (!burst) begin
        tick();
        n_chk++;
        if (RD_VALID !== 1'b0)
          $display("FAIL %s read %0d pulse width: valid=%b, required 0", name, k, RD_VALID);
        else n_pass++;
      end
    end
    RD_EN = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    tick();
    tick();
    n_chk++;
    if ({RD_DATA, RD_VALID, BUSY, DONE, TRIG_POS} !== '0)
      $display("FAIL reset_outputs: data=%h valid=%b busy=%b done=%b pos=%0d, required all 0",
               RD_DATA, RD_VALID, BUSY, DONE, TRIG_POS);
    else n_pass++;
    RST = 1'b0;
    RD_EN = 1'b1;
    SAMPLE_STB = 1'b1;
    tick();
    RD_EN = 1'b0;
    SAMPLE_STB = 1'b0;
    tick();
    n_chk++;
    if (RD_VALID !== 1'b0 || BUSY !== 1'b0 || DONE !== 1'b0)
      $display("FAIL idle_ignores_rd: valid=%b busy=%b done=%b, required 0 0 0", RD_VALID, BUSY, DONE);
    else n_pass++;
  endtask

  task automatic test_ramp;
    int t;
    TRIG_LEVEL = 8'h80;
    TRIG_RISING = 1'b1;
    arm();
    for (int i = 0; i < 24; i++) stim.push_back(8'(i * 16));
    do_capture("ramp", -1, t);
    n_chk++;
    if (t !== 8) $display("FAIL ramp model_trig: got %0d, required 8", t);
    else n_pass++;
    do_read("ramp_single", t, DEPTH, 1'b0);
    do_read("ramp_repeat", t, DEPTH + 3, 1'b1);
  endtask

  task automatic test_falling;
    int t;
    TRIG_LEVEL = 8'h80;
    TRIG_RISING = 1'b0;
    arm();
    for (int i = 0; i < 20; i++) stim.push_back(8'h80);
    do_capture("falling_flat", -1, t);
    arm();
    stim.push_back(8'hFF);
    for (int i = 1; i < 24; i++) stim.push_back(8'(256 - i * 16));
    do_capture("falling", -1, t);
    do_read("falling", t, DEPTH, 1'b1);
  endtask

  task automatic test_wrap;
    int t;
    TRIG_LEVEL = 8'h80;
    TRIG_RISING = 1'b1;
    arm();
    for (int i = 0; i < PRE + 20; i++) stim.push_back(8'h00);
    stim.push_back(8'h90);
    for (int i = 0; i < 15; i++) stim.push_back(8'($urandom));
    do_capture("wrap", -1, t);
    do_read("wrap", t, DEPTH, 1'b1);
  endtask

  task automatic test_force;
    int t;
    int fi;
    TRIG_LEVEL = 8'h80;
    TRIG_RISING = 1'b1;
    for (int r = 0; r < 2; r++) begin
      fi = (r == 0) ? 6 : int'($urandom_range(PRE, 12));
      arm();
      for (int i = 0; i < fi + POST + 3; i++) stim.push_back(8'h20);
      do_capture("force", fi, t);
      do_read("force", t, DEPTH, 1'b0);
    end
  endtask

  task automatic test_random;
    int t;
    int fi;
    for (int r = 0; r < 6; r++) begin
      TRIG_LEVEL  = 8'($urandom_range(1, 254));
      TRIG_RISING = 1'($urandom);
      fi = ($urandom_range(0, 1) == 1) ? int'($urandom_range(PRE, 25)) : -1;
      arm();
      for (int i = 0; i < 40; i++) stim.push_back(8'($urandom));
      do_capture("random", fi, t);
      if (t >= 0 && t + POST < stim.size()) do_read("random", t, DEPTH, 1'($urandom));
    end
  endtask

  task automatic test_rearm;
    int t;
    TRIG_LEVEL = 8'h80;
    TRIG_RISING = 1'b1;
    arm();
    for (int i = 0; i < 24; i++) stim.push_back(8'(i * 16));
    do_capture("rearm_pre", -1, t);
    RD_EN = 1'b1;
    tick();
    ARM = 1'b1;
    SAMPLE_STB = 1'b1;
    ADC_DATA = 8'hEE;
    tick();
    ARM = 1'b0;
    RD_EN = 1'b0;
    SAMPLE_STB = 1'b0;
    stim.delete();
    n_chk++;
    if (DONE !== 1'b0 || RD_VALID !== 1'b0 || BUSY !== 1'b1)
      $display("FAIL arm_priority: done=%b valid=%b busy=%b, required 0 0 1", DONE, RD_VALID, BUSY);
    else n_pass++;
    for (int i = 0; i < 12; i++) stim.push_back(8'(i * 16));
    do_capture("rearm_post", -1, t);
    arm();
    n_chk++;
    if (DONE !== 1'b0 || BUSY !== 1'b1)
      $display("FAIL arm_in_post: done=%b busy=%b, required 0 1", DONE, BUSY);
    else n_pass++;
    for (int i = 0; i < 22; i++) stim.push_back(8'(i * 16 + 8));
    do_capture("rearm_fresh", -1, t);
    do_read("rearm_fresh", t, DEPTH, 1'b1);
  endtask

  task automatic test_reset_mid;
    int t;
    TRIG_LEVEL = 8'h80;
    TRIG_RISING = 1'b1;
    arm();
    for (int i = 0; i < 12; i++) stim.push_back(8'(i * 16));
    do_capture("rst_post", -1, t);
    @(posedge CLK);
    #3 RST = 1'b1;
    #1;
    n_chk++;
    if ({RD_DATA, RD_VALID, BUSY, DONE, TRIG_POS} !== '0)
      $display("FAIL reset_mid_post: valid=%b busy=%b done=%b pos=%0d, required all 0",
               RD_VALID, BUSY, DONE, TRIG_POS);
    else n_pass++;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      SAMPLE_STB = 1'b1;
      RD_EN = 1'b1;
      ADC_DATA = 8'hC0;
      tick();
      SAMPLE_STB = 1'b0;
      RD_EN = 1'b0;
      tick();
      n_chk++;
      if ({RD_DATA, RD_VALID, BUSY, DONE, TRIG_POS} !== '0)
        $display("FAIL reset_stays_idle %0d: valid=%b busy=%b done=%b pos=%0d, required all 0",
                 i, RD_VALID, BUSY, DONE, TRIG_POS);
      else n_pass++;
    end
    arm();
    for (int i = 0; i < 24; i++) stim.push_back(8'(i * 16));
    do_capture("rst_read", -1, t);
    RD_EN = 1'b1;
    tick();
    tick();
    n_chk++;
    if (RD_VALID !== 1'b1 || RD_DATA !== stim[t - PRE + 1])
      $display("FAIL rst_read_pre: valid=%b data=%h, required 1 %h", RD_VALID, RD_DATA, stim[t - PRE + 1]);
    else n_pass++;
    #2 RST = 1'b1;
    #1;
    n_chk++;
    if ({RD_DATA, RD_VALID, BUSY, DONE, TRIG_POS} !== '0)
      $display("FAIL reset_mid_read: data=%h valid=%b busy=%b done=%b pos=%0d, required all 0",
               RD_DATA, RD_VALID, BUSY, DONE, TRIG_POS);
    else n_pass++;
    tick();
    RST = 1'b0;
    tick();
    RD_EN = 1'b0;
    tick();
    n_chk++;
    if (RD_VALID !== 1'b0 || DONE !== 1'b0)
      $display("FAIL reset_read_ignored: valid=%b done=%b, required 0 0", RD_VALID, DONE);
    else n_pass++;
    arm();
    n_chk++;
    if (BUSY !== 1'b1) $display("FAIL arm_after_reset: busy=%b, required 1", BUSY);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_falling();
    test_wrap();
    test_force();
    test_random();
    test_rearm();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
